// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: fetches one instruction byte-serially over a req/ack port,
// splits it into icode/ifun/rA/rB/valC, computes valP and flags status.
module y86_fetch_unit #(
    parameter logic [63:0] RESET_PC  = '0,
    parameter int unsigned IMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_ack,
    input  logic        imem_err,
    input  logic        pc_load,
    input  logic [63:0] pc_next,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic [2:0]  stat
);

    typedef enum logic [2:0] {S_B0, S_REGS, S_CONST, S_DONE, S_STOP} state_e;
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [63:0] MEM_LIMIT = 64'(IMEM_SIZE);

    state_e      state, state_n;
    logic [63:0] pc_n, addr_n, valc_n, valp_n, issue_addr;
    logic [3:0]  icode_n, ifun_n, ra_n, rb_n;
    logic [2:0]  stat_n, cnt, cnt_n;
    logic        req_n, valid_n, issue, fault;

    function automatic logic illegal_op(input logic [3:0] ic, input logic [3:0] fn);
        logic bad;
        case (ic)
            4'h2, 4'h7:              bad = (fn > 4'h6);
            4'h6:                    bad = (fn > 4'h3);
            4'hC, 4'hD, 4'hE, 4'hF:  bad = 1'b1;
            default:                 bad = (fn != 4'h0);
        endcase
        return bad;
    endfunction

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_n      = imem_req;
        addr_n     = imem_addr;
        icode_n    = icode;
        ifun_n     = ifun;
        ra_n       = rA;
        rb_n       = rB;
        valc_n     = valC;
        valp_n     = valP;
        valid_n    = instr_valid;
        stat_n     = stat;
        cnt_n      = cnt;
        issue      = 1'b0;
        issue_addr = imem_addr + 64'd1;
        fault      = 1'b0;
        case (state)
            S_B0, S_REGS, S_CONST: begin
                if (!imem_req) begin
                    // only reachable in B0 straight out of reset
                    issue      = 1'b1;
                    issue_addr = pc;
                end else if (imem_ack && imem_err) begin
                    fault = 1'b1;
                end else if (imem_ack) begin
                    case (state)
                        S_B0: begin
                            icode_n = imem_rdata[7:4];
                            ifun_n  = imem_rdata[3:0];
                            if (illegal_op(imem_rdata[7:4], imem_rdata[3:0])) begin
                                stat_n  = STAT_INS;
                                state_n = S_STOP;
                                req_n   = 1'b0;
                                valid_n = 1'b1;
                            end else begin
                                case (imem_rdata[7:4])
                                    4'h0: begin
                                        stat_n  = STAT_HLT;
                                        valp_n  = pc + 64'd1;
                                        state_n = S_STOP;
                                        req_n   = 1'b0;
                                        valid_n = 1'b1;
                                    end
                                    4'h1, 4'h9: begin
                                        valp_n  = pc + 64'd1;
                                        state_n = S_DONE;
                                        req_n   = 1'b0;
                                        valid_n = 1'b1;
                                    end
                                    4'h2, 4'h6, 4'hA, 4'hB: begin
                                        valp_n  = pc + 64'd2;
                                        state_n = S_REGS;
                                        issue   = 1'b1;
                                    end
                                    4'h3, 4'h4, 4'h5: begin
                                        valp_n  = pc + 64'd10;
                                        state_n = S_REGS;
                                        issue   = 1'b1;
                                    end
                                    default: begin
                                        valp_n  = pc + 64'd9;
                                        state_n = S_CONST;
                                        cnt_n   = '0;
                                        issue   = 1'b1;
                                    end
                                endcase
                            end
                        end
                        S_REGS: begin
                            ra_n = imem_rdata[7:4];
                            rb_n = imem_rdata[3:0];
                            if (icode inside {4'h3, 4'h4, 4'h5}) begin
                                state_n = S_CONST;
                                cnt_n   = '0;
                                issue   = 1'b1;
                            end else begin
                                state_n = S_DONE;
                                req_n   = 1'b0;
                                valid_n = 1'b1;
                            end
                        end
                        default: begin
                            valc_n[{cnt, 3'b000} +: 8] = imem_rdata;
                            if (cnt == 3'd7) begin
                                state_n = S_DONE;
                                req_n   = 1'b0;
                                valid_n = 1'b1;
                            end else begin
                                cnt_n = cnt + 3'd1;
                                issue = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (pc_load && stat == STAT_AOK) begin
                    pc_n       = pc_next;
                    icode_n    = '0;
                    ifun_n     = '0;
                    ra_n       = '1;
                    rb_n       = '1;
                    valc_n     = '0;
                    valp_n     = '0;
                    valid_n    = 1'b0;
                    state_n    = S_B0;
                    issue      = 1'b1;
                    issue_addr = pc_next;
                end
            end
            default: ;
        endcase
        // an out-of-range byte is flagged instead of requested
        if (issue) begin
            if (issue_addr < MEM_LIMIT) begin
                req_n  = 1'b1;
                addr_n = issue_addr;
            end else begin
                fault = 1'b1;
            end
        end
        if (fault) begin
            stat_n  = STAT_ADR;
            state_n = S_STOP;
            req_n   = 1'b0;
            valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_B0;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            icode       <= '0;
            ifun        <= '0;
            rA          <= '1;
            rB          <= '1;
            valC        <= '0;
            valP        <= '0;
            instr_valid <= 1'b0;
            stat        <= STAT_AOK;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            icode       <= icode_n;
            ifun        <= ifun_n;
            rA          <= ra_n;
            rB          <= rb_n;
            valC        <= valc_n;
            valP        <= valp_n;
            instr_valid <= valid_n;
            stat        <= stat_n;
            cnt         <= cnt_n;
        end
    end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: byte memory responder with wait states
// and a byte-level reference model of instruction length, fields and status.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0, imem_err = 1'b0, pc_load = 1'b0, instr_valid;
    logic [63:0] imem_addr, pc_next = '0, pc, valC, valP;
    logic [7:0]  imem_rdata = '0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [2:0]  stat;

    y86_fetch_unit #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_err(imem_err),
        .pc_load(pc_load), .pc_next(pc_next), .pc(pc), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .valP(valP), .instr_valid(instr_valid), .stat(stat)
    );

    always #5 clk = ~clk;

    logic [7:0]   mem [1024];
    int           checks = 0, errors = 0;
    int           wait_cycles = 0, wcnt = 0, ack_count = 0, oob_count = 0;
    logic [63:0]  err_addr = '1;
    logic [210:0] obs;
    assign obs = {pc, icode, ifun, rA, rB, valC, valP, stat};

    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    int          e_req;

    // memory responder: ack after wait_cycles idle cycles of each request
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            wcnt = 0; imem_ack = 1'b0; imem_err = 1'b0;
        end else if (wcnt >= wait_cycles) begin
            imem_ack   = 1'b1;
            imem_err   = (imem_addr == err_addr);
            imem_rdata = (imem_addr < 64'd1024) ? mem[imem_addr[9:0]] : 8'h00;
            if (imem_addr >= 64'd1024) oob_count++;
            ack_count++;
            wcnt = 0;
        end else begin
            imem_ack = 1'b0; imem_err = 1'b0; wcnt++;
        end
    end

    function automatic bit legal(input logic [3:0] ic, input logic [3:0] fn);
        case (ic)
            4'h2, 4'h7:             return fn <= 4'd6;
            4'h6:                   return fn <= 4'd3;
            4'hC, 4'hD, 4'hE, 4'hF: return 1'b0;
            default:                return fn == 4'd0;
        endcase
    endfunction

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 9;
        endcase
    endfunction

    task automatic model(input logic [63:0] p);
        logic [7:0]  b;
        logic [63:0] a;
        int          len;
        bit          regs;
        e_icode = '0; e_ifun = '0; e_ra = 4'hF; e_rb = 4'hF; e_valc = '0; e_valp = '0;
        e_req = 0; e_stat = 3'd1;
        if (p >= 64'd1024) begin e_stat = 3'd3; return; end
        e_req = 1;
        if (p == err_addr) begin e_stat = 3'd3; return; end
        b = mem[p[9:0]];
        e_icode = b[7:4]; e_ifun = b[3:0];
        if (!legal(e_icode, e_ifun)) begin e_stat = 3'd4; return; end
        if (e_icode == 4'h0) begin e_stat = 3'd2; e_valp = p + 64'd1; return; end
        len = ilen(e_icode);
        regs = (len == 2) || (len == 10);
        e_valp = p + 64'(len);
        for (int k = 1; k < len; k++) begin
            a = p + 64'(k);
            if (a >= 64'd1024) begin e_stat = 3'd3; return; end
            e_req++;
            if (a == err_addr) begin e_stat = 3'd3; return; end
            b = mem[a[9:0]];
            if (regs && k == 1) begin e_ra = b[7:4]; e_rb = b[3:0]; end
            else e_valc = e_valc | (64'(b) << (8 * (k - (regs ? 2 : 1))));
        end
    endtask

    task automatic launch(input bit from_reset, input logic [63:0] p, output int lat, output int acks);
        @(negedge clk);
        ack_count = 0;
        if (from_reset) rst_n = 1'b1;
        else begin pc_load = 1'b1; pc_next = p; end
        @(posedge clk); #1;
        pc_load = 1'b0;
        lat = 0;
        while (!instr_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        acks = ack_count;
    endtask

    task automatic recover();
        int l, a;
        rst_n = 1'b0;
        err_addr = '1;
        wait_cycles = 0;
        mem[0] = 8'h10;
        repeat (2) @(posedge clk);
        launch(1'b1, '0, l, a);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== {64'h0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1})
            begin errors++; $display("FAIL reset_fields got %h want reset values", obs); end
        checks++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b0, 64'h0, 1'b0})
            begin errors++; $display("FAIL reset_port got %b/%h/%b", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_irmovq_reset();
        int lat, acks;
        logic [7:0] img [10];
        img = '{8'h30, 8'hF2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 10; i++) mem[i] = img[i];
        wait_cycles = 0; err_addr = '1;
        model(64'h0);
        launch(1'b1, '0, lat, acks);
        checks++;
        if (obs !== {64'h0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0807060504030201, 64'd10, 3'd1})
            begin errors++; $display("FAIL irmovq_fields got %h want fixed irmovq", obs); end
        checks++;
        if (lat != 10 || acks != 10) begin errors++; $display("FAIL irmovq_timing got lat %0d acks %0d want 10 10", lat, acks); end
    endtask

    task automatic test_addq_load();
        int lat, acks;
        mem[32] = 8'h60; mem[33] = 8'h23;
        wait_cycles = 3;
        launch(1'b0, 64'h20, lat, acks);
        checks++;
        if (obs !== {64'h20, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h22, 3'd1})
            begin errors++; $display("FAIL addq_fields got %h", obs); end
        checks++;
        if (lat != 8 || acks != 2) begin errors++; $display("FAIL addq_timing got lat %0d acks %0d want 8 2", lat, acks); end
    endtask

    task automatic test_ins();
        int lat, acks;
        logic [7:0] codes [2];
        codes = '{8'hC0, 8'h65};
        foreach (codes[i]) begin
            recover();
            mem[64] = codes[i];
            model(64'h40);
            launch(1'b0, 64'h40, lat, acks);
            checks++;
            if ({icode, ifun, stat, acks} !== {e_icode, e_ifun, 3'd4, 32'd1})
                begin errors++; $display("FAIL ins_%0d got %h%h stat %0d acks %0d want stat 4 acks 1", i, icode, ifun, stat, acks); end
            @(negedge clk); pc_load = 1'b1; pc_next = 64'h0;
            @(posedge clk); #1; pc_load = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if ({pc, instr_valid, imem_req, stat} !== {64'h40, 1'b1, 1'b0, 3'd4})
                begin errors++; $display("FAIL ins_stop_%0d got pc %h v %b req %b stat %0d", i, pc, instr_valid, imem_req, stat); end
        end
    endtask

    task automatic test_adr_boundary();
        int lat, acks;
        recover();
        mem[1016] = 8'h30; mem[1017] = 8'hF4;
        for (int i = 1018; i < 1024; i++) mem[i] = 8'($urandom);
        model(64'd1016);
        launch(1'b0, 64'd1016, lat, acks);
        checks++;
        if (stat !== 3'd3 || acks != 8 || e_req != 8)
            begin errors++; $display("FAIL adr_boundary got stat %0d acks %0d want 3 8", stat, acks); end
        checks++;
        if (oob_count != 0) begin errors++; $display("FAIL adr_no_oob_req got %0d want 0", oob_count); end
        checks++;
        if (lat != 8 || instr_valid !== 1'b1) begin errors++; $display("FAIL adr_timing got %0d want 8", lat); end
    endtask

    task automatic test_imem_err();
        int lat, acks;
        recover();
        mem[128] = 8'h80;
        for (int i = 129; i < 137; i++) mem[i] = 8'($urandom);
        err_addr = 64'd131;
        wait_cycles = 1;
        model(64'd128);
        launch(1'b0, 64'd128, lat, acks);
        checks++;
        if (stat !== 3'd3 || acks != 4 || lat != 8)
            begin errors++; $display("FAIL imem_err got stat %0d acks %0d lat %0d want 3 4 8", stat, acks, lat); end
        err_addr = '1;
    endtask

    task automatic test_halt();
        int lat, acks;
        recover();
        mem[80] = 8'h00;
        launch(1'b0, 64'd80, lat, acks);
        checks++;
        if (obs !== {64'd80, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd81, 3'd2} || lat != 1)
            begin errors++; $display("FAIL halt got %h lat %0d", obs, lat); end
        @(negedge clk); pc_load = 1'b1; pc_next = 64'h200;
        @(negedge clk); pc_load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if ({obs, instr_valid} !== {64'd80, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd81, 3'd2, 1'b1})
            begin errors++; $display("FAIL halt_hold got %h v %b", obs, instr_valid); end
    endtask

    task automatic test_wrap();
        int lat, acks;
        recover();
        launch(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, lat, acks);
        checks++;
        if (stat !== 3'd3 || lat != 0 || acks != 0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL wrap_adr got stat %0d lat %0d acks %0d", stat, lat, acks); end
    endtask

    task automatic test_reset_mid_fetch();
        recover();
        mem[256] = 8'h30; mem[257] = 8'hF1;
        wait_cycles = 2;
        @(negedge clk); pc_load = 1'b1; pc_next = 64'h100;
        @(posedge clk); #1; pc_load = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_busy got req %b want 1", imem_req); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {64'h0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1} ||
            {imem_req, imem_addr, instr_valid} !== {1'b0, 64'h0, 1'b0})
            begin errors++; $display("FAIL midfetch_reset got %h req %b addr %h", obs, imem_req, imem_addr); end
    endtask

    task automatic test_random();
        int lat, acks, len;
        logic [63:0] p;
        logic [3:0] ic, fn;
        bit stopped = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (stopped) recover();
            p = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(1012, 1023)) : 64'($urandom_range(64, 1000));
            for (int k = 0; k < 10; k++) if (p + 64'(k) < 64'd1024) mem[p[9:0] + 10'(k)] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                ic = 4'($urandom_range(1, 11));
                fn = (ic == 4'h2 || ic == 4'h7) ? 4'($urandom_range(0, 6)) :
                     (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'h0;
                mem[p[9:0]] = {ic, fn};
            end
            len = ilen(mem[p[9:0]][7:4]);
            wait_cycles = $urandom_range(0, 2);
            err_addr = ($urandom_range(0, 5) == 0) ? p + 64'($urandom_range(0, len - 1)) : '1;
            model(p);
            launch(1'b0, p, lat, acks);
            checks++;
            if (e_stat == 3'd1 || e_stat == 3'd2) begin
                if (obs !== {p, e_icode, e_ifun, e_ra, e_rb, e_valc, e_valp, e_stat})
                    begin errors++; $display("FAIL rand_fields_%0d got %h want %h", it, obs, {p, e_icode, e_ifun, e_ra, e_rb, e_valc, e_valp, e_stat}); end
            end else if (e_stat == 3'd4) begin
                if ({icode, ifun, stat} !== {e_icode, e_ifun, e_stat})
                    begin errors++; $display("FAIL rand_ins_%0d got %h%h/%0d want %h%h/4", it, icode, ifun, stat, e_icode, e_ifun); end
            end else if (stat !== e_stat) begin
                errors++; $display("FAIL rand_stat_%0d got %0d want %0d", it, stat, e_stat);
            end
            checks++;
            if (lat != e_req * (wait_cycles + 1) || acks != e_req)
                begin errors++; $display("FAIL rand_timing_%0d got lat %0d acks %0d want %0d %0d", it, lat, acks, e_req * (wait_cycles + 1), e_req); end
            stopped = (e_stat != 3'd1);
            err_addr = '1;
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        test_reset();
        test_irmovq_reset();
        test_addq_load();
        test_ins();
        test_adr_boundary();
        test_imem_err();
        test_halt();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        checks++;
        if (oob_count != 0) begin errors++; $display("FAIL oob_requests got %0d want 0", oob_count); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
